fp_mult_pipe: RTL



---
 rtl/fp_mult_pkg.sv | 57 +++++
 rtl/fp_round.sv | 35 +++
 rtl/fp_mult_pipe.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fp_mult_pkg.sv
// Shared types, status bit positions and IEEE-754 single constants
// for the pipelined single-precision multiplier.
package fp_mult_pkg;

  typedef enum logic [2:0] {
    RND_NEAR    = 3'b000,
    RND_ZERO    = 3'b001,
    RND_PINF    = 3'b010,
    RND_NINF    = 3'b011,
    RND_NEAR_UP = 3'b100,
    RND_AWAY    = 3'b101,
    RND_RSVD6   = 3'b110,
    RND_RSVD7   = 3'b111
  } round_mode_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } operand_class_t;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_INVALID = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 254;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] INF_MAG  = 32'h7F80_0000;
  localparam logic [31:0] MAX_NORM = 32'h7F7F_FFFF;
  localparam logic [31:0] MIN_NORM = 32'h0080_0000;

  // Denormals (exp==0) are treated as zero regardless of mantissa.
  function automatic operand_class_t classify(input logic [30:0] mag);
    if (mag[30:23] == 8'd0)  return CLS_ZERO;
    if (mag[30:23] != 8'hFF) return CLS_NORM;
    return (mag[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
  endfunction

  // True when the mode pushes an out-of-range result away from zero.
  // near_mag selects how the round-to-nearest family behaves.
  function automatic logic toward_mag(input round_mode_t mode, input logic sign,
                                      input logic near_mag);
    case (mode)
      RND_ZERO: return 1'b0;
      RND_PINF: return ~sign;
      RND_NINF: return sign;
      RND_AWAY: return 1'b1;
      default:  return near_mag;
    endcase
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational rounder: applies one of the rounding modes to a normalised
// 24-bit mantissa using guard/sticky, reporting carry-out and inexact.
module fp_round
  import fp_mult_pkg::*;
(
  input  logic        sign,
  input  logic [23:0] mant,
  input  logic        guard,
  input  logic        sticky,
  input  round_mode_t mode,
  output logic [23:0] mant_rnd,
  output logic        carry,
  output logic        inexact
);

  logic inc;

  assign inexact = guard | sticky;

  always_comb begin
    inc = 1'b0;
    case (mode)
      RND_ZERO:    inc = 1'b0;
      RND_PINF:    inc = inexact & ~sign;
      RND_NINF:    inc = inexact & sign;
      // Ties go toward +inf: up in magnitude only for positive results.
      RND_NEAR_UP: inc = guard & (sticky | ~sign);
      RND_AWAY:    inc = inexact;
      default:     inc = guard & (sticky | mant[0]);
    endcase
  end

  assign {carry, mant_rnd} = {1'b0, mant} + {24'd0, inc};

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-754 single multiplier: S1 operand capture, S2 classify and
// multiply, S3 normalise/round/exceptions. Valid-tagged, no backpressure.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rnd,
  output logic        out_valid,
  output logic [31:0] z,
  output logic [7:0]  status
);

  localparam logic signed [9:0] EXP_HI = 10'(EXP_MAX);
  localparam logic signed [9:0] EXP_LO = 10'sd1;

  logic [LATENCY-1:0] vld;

  logic [31:0] s1_a, s1_b;
  round_mode_t s1_rnd;

  logic              s2_sign;
  logic [47:0]       s2_prod;
  logic signed [9:0] s2_exp;
  operand_class_t    s2_cls_a, s2_cls_b;
  round_mode_t       s2_rnd;

  logic [47:0]       prod_c;
  logic signed [9:0] exp_c;

  logic              norm_shift, guard_n, sticky_n;
  logic [23:0]       mant_n, mant_rnd;
  logic signed [9:0] exp_n, exp_r;
  logic              carry, inexact;
  logic              is_nan, is_inf, is_zero;
  logic [31:0]       z_nxt;
  logic [7:0]        st_nxt;
  logic              unused_mant_msb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld <= '0;
    else      vld <= {vld[LATENCY-2:0], in_valid};
  end

  assign out_valid = vld[LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_rnd <= RND_NEAR;
    end else if (in_valid) begin
      s1_a   <= a;
      s1_b   <= b;
      s1_rnd <= round_mode_t'(rnd);
    end
  end

  assign prod_c = {24'd0, 1'b1, s1_a[22:0]} * {24'd0, 1'b1, s1_b[22:0]};
  assign exp_c  = $signed({2'b00, s1_a[30:23]}) + $signed({2'b00, s1_b[30:23]})
                - $signed(10'(EXP_BIAS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_sign  <= 1'b0;
      s2_prod  <= '0;
      s2_exp   <= '0;
      s2_cls_a <= CLS_ZERO;
      s2_cls_b <= CLS_ZERO;
      s2_rnd   <= RND_NEAR;
    end else if (vld[0]) begin
      s2_sign  <= s1_a[31] ^ s1_b[31];
      s2_prod  <= prod_c;
      s2_exp   <= exp_c;
      s2_cls_a <= classify(s1_a[30:0]);
      s2_cls_b <= classify(s1_b[30:0]);
      s2_rnd   <= s1_rnd;
    end
  end

  // Product of two [1,2) mantissas lies in [1,4): at most one right shift.
  assign norm_shift = s2_prod[47];
  assign mant_n     = norm_shift ? s2_prod[47:24] : s2_prod[46:23];
  assign guard_n    = norm_shift ? s2_prod[23]    : s2_prod[22];
  assign sticky_n   = norm_shift ? |s2_prod[22:0] : |s2_prod[21:0];
  assign exp_n      = s2_exp + $signed({9'd0, norm_shift});

  fp_round u_round (
    .sign     (s2_sign),
    .mant     (mant_n),
    .guard    (guard_n),
    .sticky   (sticky_n),
    .mode     (s2_rnd),
    .mant_rnd (mant_rnd),
    .carry    (carry),
    .inexact  (inexact)
  );

  // On carry-out the rounded mantissa is all zeros, so the fraction is already 0.
  assign exp_r           = exp_n + $signed({9'd0, carry});
  assign unused_mant_msb = mant_rnd[23];

  assign is_nan  = (s2_cls_a == CLS_NAN)  || (s2_cls_b == CLS_NAN);
  assign is_inf  = (s2_cls_a == CLS_INF)  || (s2_cls_b == CLS_INF);
  assign is_zero = (s2_cls_a == CLS_ZERO) || (s2_cls_b == CLS_ZERO);

  always_comb begin
    z_nxt  = {s2_sign, exp_r[7:0], mant_rnd[22:0]};
    st_nxt = '0;
    st_nxt[ST_INEXACT] = inexact;
    if (is_nan || (is_zero && is_inf)) begin
      z_nxt  = QNAN;
      st_nxt = '0;
      st_nxt[ST_INVALID] = 1'b1;
    end else if (is_inf) begin
      z_nxt  = {s2_sign, INF_MAG[30:0]};
      st_nxt = '0;
      st_nxt[ST_INF] = 1'b1;
    end else if (is_zero) begin
      z_nxt  = {s2_sign, 31'd0};
      st_nxt = '0;
      st_nxt[ST_ZERO] = 1'b1;
    end else if (exp_r > EXP_HI) begin
      st_nxt = '0;
      if (toward_mag(s2_rnd, s2_sign, 1'b1)) begin
        z_nxt = {s2_sign, INF_MAG[30:0]};
        st_nxt[ST_INF] = 1'b1;
      end else begin
        z_nxt = {s2_sign, MAX_NORM[30:0]};
        st_nxt[ST_HUGE]    = 1'b1;
        st_nxt[ST_INEXACT] = 1'b1;
      end
    end else if (exp_r < EXP_LO) begin
      st_nxt = '0;
      if (toward_mag(s2_rnd, s2_sign, 1'b0)) begin
        z_nxt = {s2_sign, MIN_NORM[30:0]};
        st_nxt[ST_TINY]    = 1'b1;
        st_nxt[ST_INEXACT] = 1'b1;
      end else begin
        z_nxt = {s2_sign, 31'd0};
        st_nxt[ST_ZERO] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z      <= '0;
      status <= '0;
    end else if (vld[1]) begin
      z      <= z_nxt;
      status <= st_nxt;
    end
  end

endmodule
